hub_slot_sched: RTL



---
 rtl/hub_slot_sched.sv | 96 +++++++++
 1 files changed

// File: rtl/hub_slot_sched.sv
// Hub slot scheduler: fixed or demand-skipping cog round-robin with
// per-cog slot wait tracking and a worst-case wait report.
module hub_slot_sched #(
    parameter int COGS   = 8,
    parameter int WAIT_W = 4
) (
    input  logic              clk_cog,
    input  logic              nres,
    input  logic              mode_dyn,
    input  logic [COGS-1:0]   cog_ena,
    input  logic [COGS-1:0]   bus_req,
    input  logic              stat_clr,
    output logic              ena_bus,
    output logic [COGS-1:0]   bus_sel,
    output logic [2:0]        slot_cog,
    output logic              slot_vld,
    output logic [WAIT_W-1:0] max_wait,
    output logic [2:0]        max_cog
);

    logic [COGS-1:0]   cand;
    logic [2:0]        base;
    logic [2:0]        pick;
    logic              hit;
    logic [2:0]        nxt_cog;
    logic [COGS-1:0]   nxt_sel;
    logic [WAIT_W-1:0] wait_cnt [COGS];
    logic [WAIT_W-1:0] gcnt;
    logic [WAIT_W-1:0] mw_base;
    logic              upd;

    assign cand = cog_ena & bus_req;

    // base is both the fixed-mode successor and the first demand candidate
    assign base = slot_vld ? slot_cog + 3'd1 : 3'd0;

    always_comb begin
        logic [2:0] idx;
        idx  = 3'd0;
        hit  = 1'b0;
        pick = base;
        for (int k = 0; k < COGS; k++) begin
            idx = base + 3'(k);
            if (!hit && cand[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
    end

    assign nxt_cog = (mode_dyn && hit) ? pick : base;
    assign nxt_sel = {{(COGS-1){1'b0}}, 1'b1} << nxt_cog;

    // a clear coinciding with a grant compares against a zero baseline
    assign gcnt    = wait_cnt[nxt_cog];
    assign mw_base = stat_clr ? '0 : max_wait;
    assign upd     = ena_bus && cand[nxt_cog] && (gcnt > mw_base);

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            ena_bus  <= 1'b0;
            bus_sel  <= '0;
            slot_cog <= 3'd0;
            slot_vld <= 1'b0;
            max_wait <= '0;
            max_cog  <= 3'd0;
            for (int i = 0; i < COGS; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            ena_bus <= ~ena_bus;
            if (ena_bus) begin
                bus_sel  <= nxt_sel;
                slot_cog <= nxt_cog;
                slot_vld <= 1'b1;
                for (int i = 0; i < COGS; i++) begin
                    if (cand[i] && (3'(i) != nxt_cog)) begin
                        if (wait_cnt[i] != '1) begin
                            wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
                        end
                    end else begin
                        wait_cnt[i] <= '0;
                    end
                end
            end
            if (upd) begin
                max_wait <= gcnt;
                max_cog  <= nxt_cog;
            end else if (stat_clr) begin
                max_wait <= '0;
                max_cog  <= 3'd0;
            end
        end
    end

endmodule
